draw_sequencer: RTL and testbench

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

---
 rtl/draw_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_draw_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// Draw request sequencer: queues shape requests in a FIFO and steps the draw
// stage through N(img) pixel indices per request, issuing one VGA plot per pixel.
module draw_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [4:0] req_img,
    input  logic [6:0] req_x,
    input  logic [6:0] req_y,
    input  logic [2:0] req_colour,
    output logic       draw_en,
    output logic [6:0] draw_img,
    output logic [6:0] draw_sx,
    output logic [6:0] draw_sy,
    output logic [3:0] draw_counter,
    output logic       plot,
    output logic [2:0] colour,
    output logic       busy,
    output logic       done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = 5 + 7 + 7 + 3;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t         state;
    state_t         state_next;

    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           push;
    logic           pop;

    logic [4:0]     img_r;
    logic [6:0]     x_r;
    logic [6:0]     y_r;
    logic [2:0]     col_r;
    logic [3:0]     n_cur;

    logic           draw_en_next;
    logic [3:0]     counter_next;
    logic           done_next;

    // Pixels emitted per shape code; unknown codes draw nothing.
    function automatic logic [3:0] pixel_count(input logic [4:0] img);
        logic [3:0] n;
        case (img)
            5'd1:    n = 4'd9;
            5'd2:    n = 4'd5;
            5'd3:    n = 4'd9;
            5'd4:    n = 4'd14;
            5'd5:    n = 4'd11;
            5'd6:    n = 4'd12;
            5'd7:    n = 4'd13;
            5'd8:    n = 4'd8;
            5'd9:    n = 4'd11;
            5'd10:   n = 4'd13;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    // req_ready is registered as !full, so a pop in a full cycle cannot admit a push.
    assign push  = req_valid && req_ready;
    assign n_cur = pixel_count(img_r);

    assign draw_img = {2'b00, img_r};
    assign draw_sx  = x_r;
    assign draw_sy  = y_r;
    assign colour   = col_r;

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Next state and next values of the registered draw-stage outputs.
    always_comb begin
        state_next   = state;
        draw_en_next = draw_en;
        counter_next = draw_counter;
        done_next    = 1'b0;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                draw_en_next = 1'b0;
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (n_cur == 4'd0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    draw_en_next = 1'b1;
                    counter_next = 4'd0;
                    state_next   = RUN;
                end
            end
            RUN: begin
                if (draw_counter == n_cur - 4'd1) begin
                    // done rises with the final plot, which lands in DRAIN.
                    draw_en_next = 1'b0;
                    done_next    = 1'b1;
                    state_next   = DRAIN;
                end else begin
                    counter_next = draw_counter + 4'd1;
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next   = IDLE;
                draw_en_next = 1'b0;
            end
        endcase
    end

    // FIFO storage; stale contents are harmless because pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_img, req_x, req_y, req_colour};
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            req_ready <= (count_next != FULL_COUNT);
        end
    end

    // Working registers hold the active request from LOAD through DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            img_r <= '0;
            x_r   <= '0;
            y_r   <= '0;
            col_r <= '0;
        end else if (pop) begin
            {img_r, x_r, y_r, col_r} <= mem[rd_ptr];
        end
    end

    // State register and registered draw/VGA outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            draw_en      <= 1'b0;
            draw_counter <= '0;
            plot         <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            draw_en      <= draw_en_next;
            draw_counter <= counter_next;
            plot         <= draw_en;
            done         <= done_next;
            busy         <= (state_next != IDLE) || (count_next != '0);
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: directed scenarios plus random traffic
// compared against a request-level model of the expected pixel/plot stream.
module tb_draw_sequencer;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_img;
    logic [6:0] req_x;
    logic [6:0] req_y;
    logic [2:0] req_colour;
    logic       draw_en;
    logic [6:0] draw_img;
    logic [6:0] draw_sx;
    logic [6:0] draw_sy;
    logic [3:0] draw_counter;
    logic       plot;
    logic [2:0] colour;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [4:0] img;
        logic [6:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } req_t;

    typedef struct {
        int         cyc;
        logic [6:0] img;
        logic [6:0] sx;
        logic [6:0] sy;
        logic [3:0] cnt;
    } en_rec_t;

    typedef struct {
        int         cyc;
        logic [2:0] c;
    } pl_rec_t;

    req_t    exp_q[$];
    en_rec_t en_q[$];
    pl_rec_t pl_q[$];
    int      dn_q[$];

    draw_sequencer #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_img      (req_img),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_colour   (req_colour),
        .draw_en      (draw_en),
        .draw_img     (draw_img),
        .draw_sx      (draw_sx),
        .draw_sy      (draw_sy),
        .draw_counter (draw_counter),
        .plot         (plot),
        .colour       (colour),
        .busy         (busy),
        .done         (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Log draw beats, plots and done pulses mid-cycle for stream checking.
    always @(negedge clk) begin
        en_rec_t e;
        pl_rec_t p;
        cyc = cyc + 1;
        if (draw_en === 1'b1) begin
            e.cyc = cyc; e.img = draw_img; e.sx = draw_sx; e.sy = draw_sy; e.cnt = draw_counter;
            en_q.push_back(e);
        end
        if (plot === 1'b1) begin
            p.cyc = cyc; p.c = colour;
            pl_q.push_back(p);
        end
        if (done === 1'b1) dn_q.push_back(cyc);
    end

    function automatic int ntab(input logic [4:0] img);
        case (img)
            5'd1: return 9;   5'd2: return 5;   5'd3: return 9;   5'd4: return 14;
            5'd5: return 11;  5'd6: return 12;  5'd7: return 13;  5'd8: return 8;
            5'd9: return 11;  5'd10: return 13;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_logs();
        exp_q.delete();
        en_q.delete();
        pl_q.delete();
        dn_q.delete();
    endtask

    // Offer one request from the next falling edge; returns just after the accept edge.
    task automatic push(input logic [4:0] img, input logic [6:0] x, input logic [6:0] y,
                        input logic [2:0] c);
        req_t r;
        bit   accepted = 0;
        @(negedge clk);
        req_valid = 1'b1; req_img = img; req_x = x; req_y = y; req_colour = c;
        for (int i = 0; i < 200; i++) begin
            if (req_ready === 1'b1) begin
                @(posedge clk);
                #1;
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        if (accepted) begin
            r.img = img; r.x = x; r.y = y; r.c = c;
            exp_q.push_back(r);
        end else begin
            check("push_timeout", 0, 1);
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    // Compare the logged streams against the queued requests, in order.
    task automatic verify_stream(input string name);
        int total = 0;
        int b     = 0;
        foreach (exp_q[i]) total += ntab(exp_q[i].img);
        check({name, " draw beats"}, en_q.size(), total);
        check({name, " plots"}, pl_q.size(), total);
        check({name, " dones"}, dn_q.size(), exp_q.size());
        if (en_q.size() == total && pl_q.size() == total && dn_q.size() == exp_q.size()) begin
            for (int r = 0; r < exp_q.size(); r++) begin
                int n = ntab(exp_q[r].img);
                for (int j = 0; j < n; j++) begin
                    check($sformatf("%s r%0d p%0d counter", name, r, j), en_q[b].cnt, j);
                    check($sformatf("%s r%0d p%0d img", name, r, j), en_q[b].img, {2'b00, exp_q[r].img});
                    check($sformatf("%s r%0d p%0d sx", name, r, j), en_q[b].sx, exp_q[r].x);
                    check($sformatf("%s r%0d p%0d sy", name, r, j), en_q[b].sy, exp_q[r].y);
                    check($sformatf("%s r%0d p%0d colour", name, r, j), pl_q[b].c, exp_q[r].c);
                    check($sformatf("%s r%0d p%0d plot lag", name, r, j), pl_q[b].cyc, en_q[b].cyc + 1);
                    if (j > 0)
                        check($sformatf("%s r%0d p%0d gap", name, r, j), pl_q[b].cyc, pl_q[b-1].cyc + 1);
                    b++;
                end
                if (n > 0)
                    check($sformatf("%s r%0d done align", name, r), dn_q[r], pl_q[b-1].cyc);
            end
        end
    endtask

    initial begin
        logic [4:0] rimg;
        clk = 1'b0; reset = 1'b1; req_valid = 1'b0;
        req_img = '0; req_x = '0; req_y = '0; req_colour = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst req_ready", req_ready, 1);
        check("rst draw_en", draw_en, 0);
        check("rst plot", plot, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst draw_counter", draw_counter, 0);
        check("rst draw_img", draw_img, 0);
        check("rst colour", colour, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // img=2 into idle block: exact cycle timing after the accept edge
        clear_logs();
        push(5'd2, 7'd50, 7'd40, 3'b100);
        req_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("t1 k%0d plot", k), plot, (k >= 3 && k <= 7));
            check($sformatf("t1 k%0d done", k), done, (k == 7));
            check($sformatf("t1 k%0d draw_en", k), draw_en, (k >= 2 && k <= 6));
            check($sformatf("t1 k%0d busy", k), busy, (k <= 7));
            if (k >= 2 && k <= 6) check($sformatf("t1 k%0d counter", k), draw_counter, k - 2);
            if (k >= 7) check($sformatf("t1 k%0d counter hold", k), draw_counter, 4);
            if (k >= 3 && k <= 7) begin
                check($sformatf("t1 k%0d colour", k), colour, 3'b100);
                check($sformatf("t1 k%0d sx", k), draw_sx, 50);
                check($sformatf("t1 k%0d sy", k), draw_sy, 40);
                check($sformatf("t1 k%0d img", k), draw_img, 2);
            end
        end
        verify_stream("t1");

        // img=4: fourteen plots, counter tops out at 13, back to idle
        clear_logs();
        push(5'd4, 7'd3, 7'd120, 3'b011);
        req_valid = 1'b0;
        wait_idle(100, "t2 idle");
        verify_stream("t2");
        check("t2 final counter", draw_counter, 13);
        check("t2 busy", busy, 0);

        // img=20: no pixels, done two cycles after accept
        clear_logs();
        push(5'd20, 7'd9, 7'd9, 3'b111);
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("t3 k%0d done", k), done, (k == 2));
            check($sformatf("t3 k%0d plot", k), plot, 0);
            check($sformatf("t3 k%0d draw_en", k), draw_en, 0);
        end
        verify_stream("t3");

        // Five back-to-back pushes while a request runs: FIFO fills at four
        clear_logs();
        push(5'd3, 7'd10, 7'd11, 3'b001);
        req_valid = 1'b0;
        begin
            bit seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (draw_en === 1'b1) begin seen = 1; break; end
            end
            check("t4 first running", seen, 1);
        end
        push(5'd2, 7'd20, 7'd21, 3'b010);
        push(5'd8, 7'd30, 7'd31, 3'b011);
        push(5'd1, 7'd40, 7'd41, 3'b100);
        push(5'd20, 7'd50, 7'd51, 3'b101);
        req_valid = 1'b0;
        @(negedge clk);
        check("t4 ready after 4 queued", req_ready, 0);
        check("t4 busy while full", busy, 1);
        push(5'd6, 7'd60, 7'd61, 3'b110);
        req_valid = 1'b0;
        wait_idle(300, "t4 idle");
        verify_stream("t4");

        // Reset at draw_counter=3 of img=1 with two requests queued
        clear_logs();
        push(5'd1, 7'd70, 7'd71, 3'b001);
        push(5'd2, 7'd72, 7'd73, 3'b010);
        push(5'd5, 7'd74, 7'd75, 3'b011);
        req_valid = 1'b0;
        begin
            bit hit = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (draw_en === 1'b1 && draw_counter == 4'd3 && draw_img == 7'd1) begin
                    hit = 1; break;
                end
            end
            check("t5 reached counter 3", hit, 1);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        check("t5 plot after reset", plot, 0);
        check("t5 busy after reset", busy, 0);
        check("t5 done after reset", done, 0);
        check("t5 draw_en after reset", draw_en, 0);
        check("t5 ready after reset", req_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("t5 no plots", pl_q.size(), 0);
        check("t5 no dones", dn_q.size(), 0);
        check("t5 no draw beats", en_q.size(), 0);
        check("t5 still idle", busy, 0);

        // Random traffic against the request-level model
        clear_logs();
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) rimg = 5'($urandom_range(11, 31));
            else if ($urandom_range(0, 7) == 0) rimg = 5'd0;
            else rimg = 5'($urandom_range(1, 10));
            push(rimg, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                 3'($urandom_range(0, 7)));
            req_valid = 1'b0;
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wait_idle(600, "rand idle");
        verify_stream("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
